// File: rtl/sim_ctrl_pkg.sv
// Shared types and helpers for the simulation run controller.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_e;

    // All-ones value of a w-bit counter: the saturation ceiling.
    function automatic int unsigned sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_run_controller_popcount_prio.sv
// Combinational failure counter and lowest-set-bit priority encoder.
module popcount_prio #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] count_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan high-to-low so the lowest set index is the last one written.
    always_comb begin
        count_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bits_i[i]) begin
                count_o = count_o + CW'(1);
                idx_o   = IW'(i);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: DUT reset sequencing, cycle budget and checker verdict aggregation.
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CHECKS   = 4,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 200,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ERR_W        = 8,
    localparam int unsigned ID_W        = id_width(NUM_CHECKS)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic [NUM_CHECKS-1:0] check_valid_i,
    input  logic [NUM_CHECKS-1:0] check_fail_i,
    output logic                  dut_reset_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ERR_W-1:0]      error_count_o,
    output logic [ID_W-1:0]       first_fail_id_o,
    output logic                  fail_seen_o,
    output logic [CNT_W-1:0]      cycle_count_o
);

    localparam int unsigned PC_W   = $clog2(NUM_CHECKS + 1);
    localparam int unsigned HOLD_W = id_width(RESET_CYCLES);
    localparam int unsigned SUM_W  = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'(sat_max(ERR_W));

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ID_W-1:0]     ffid_q, ffid_d;
    logic                seen_q, seen_d;
    logic                tmo_q, tmo_d;
    logic                dres_q, run_q, done_q, pass_q;

    logic [NUM_CHECKS-1:0] fail_vec;
    logic [PC_W-1:0]       fail_cnt;
    logic [ID_W-1:0]       fail_idx;
    logic                  fail_any;
    logic [SUM_W-1:0]      err_sum;

    assign fail_vec = check_valid_i & check_fail_i;
    assign err_sum  = SUM_W'(err_q) + SUM_W'(fail_cnt);

    popcount_prio #(
        .N  (NUM_CHECKS),
        .CW (PC_W),
        .IW (ID_W)
    ) u_popcount_prio (
        .bits_i  (fail_vec),
        .count_o (fail_cnt),
        .idx_o   (fail_idx),
        .any_o   (fail_any)
    );

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cycle_d = cycle_q;
        err_d   = err_q;
        ffid_d  = ffid_q;
        seen_d  = seen_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RESET_HOLD;
                    hold_d  = '0;
                    cycle_d = '0;
                    err_d   = '0;
                    ffid_d  = '0;
                    seen_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RESET_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                err_d   = (err_sum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(err_sum);
                if (fail_any && !seen_q) begin
                    seen_d = 1'b1;
                    ffid_d = fail_idx;
                end
                // Halt takes priority over budget expiry.
                if (halt_i) begin
                    state_d = DONE;
                end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cycle_q <= '0;
            err_q   <= '0;
            ffid_q  <= '0;
            seen_q  <= 1'b0;
            tmo_q   <= 1'b0;
            dres_q  <= 1'b1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
            ffid_q  <= ffid_d;
            seen_q  <= seen_d;
            tmo_q   <= tmo_d;
            dres_q  <= (state_d != RUN);
            run_q   <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            pass_q  <= (state_d == DONE) && !seen_d && !tmo_d;
        end
    end

    assign dut_reset_o     = dres_q;
    assign running_o       = run_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = tmo_q;
    assign error_count_o   = err_q;
    assign first_fail_id_o = ffid_q;
    assign fail_seen_o     = seen_q;
    assign cycle_count_o   = cycle_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: two parameterisations driven in lockstep against a behavioural model.
module tb_sim_run_controller;

    localparam int P_IDLE = 0;
    localparam int P_HOLD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    typedef struct packed {
        int phase;
        int hold_left;
        int cycles;
        int errs;
        int ffid;
        int seen;
        int tmo;
    } model_t;

    logic       clk = 1'b0;
    logic       rst, st, hlt;
    logic [3:0] cv, cf;

    logic        a_dres, a_run, a_done, a_pass, a_tmo, a_seen;
    logic [7:0]  a_err;
    logic [1:0]  a_ffid;
    logic [15:0] a_cyc;

    logic        s_dres, s_run, s_done, s_pass, s_tmo, s_seen;
    logic [2:0]  s_err;
    logic [1:0]  s_ffid;
    logic [7:0]  s_cyc;

    int     total = 0;
    int     bad   = 0;
    model_t ma, ms;

    always #5 clk = ~clk;

    sim_run_controller u_dut_a (
        .clock_i(clk), .reset_i(rst), .start_i(st), .halt_i(hlt),
        .check_valid_i(cv), .check_fail_i(cf),
        .dut_reset_o(a_dres), .running_o(a_run), .done_o(a_done), .pass_o(a_pass),
        .timeout_o(a_tmo), .error_count_o(a_err), .first_fail_id_o(a_ffid),
        .fail_seen_o(a_seen), .cycle_count_o(a_cyc)
    );

    sim_run_controller #(
        .NUM_CHECKS(4), .RESET_CYCLES(3), .MAX_CYCLES(20), .CNT_W(8), .ERR_W(3)
    ) u_dut_s (
        .clock_i(clk), .reset_i(rst), .start_i(st), .halt_i(hlt),
        .check_valid_i(cv), .check_fail_i(cf),
        .dut_reset_o(s_dres), .running_o(s_run), .done_o(s_done), .pass_o(s_pass),
        .timeout_o(s_tmo), .error_count_o(s_err), .first_fail_id_o(s_ffid),
        .fail_seen_o(s_seen), .cycle_count_o(s_cyc)
    );

    // One cycle of the run controller's rules, in terms of phases and remaining hold cycles.
    function automatic model_t mstep(model_t m, bit r, bit s, bit h, bit [3:0] v, bit [3:0] f,
                                     int rc, int mc, int emax);
        bit [3:0] fl;
        int       n;
        fl = v & f;
        if (r) begin
            m = '0;
        end else if (m.phase == P_IDLE || m.phase == P_DONE) begin
            if (s) begin
                m           = '0;
                m.phase     = P_HOLD;
                m.hold_left = rc;
            end
        end else if (m.phase == P_HOLD) begin
            m.hold_left = m.hold_left - 1;
            if (m.hold_left == 0) m.phase = P_RUN;
        end else begin
            m.cycles = m.cycles + 1;
            n        = $countones(fl);
            m.errs   = (m.errs + n > emax) ? emax : m.errs + n;
            if (fl != 0 && m.seen == 0) begin
                m.seen = 1;
                for (int i = 3; i >= 0; i--) if (fl[i]) m.ffid = i;
            end
            if (h) begin
                m.phase = P_DONE;
            end else if (m.cycles == mc) begin
                m.phase = P_DONE;
                m.tmo   = 1;
            end
        end
        return m;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(string tag, model_t m, logic dres, logic run, logic dn, logic ps,
                             logic tmo, int cyc, int err, int ffid, logic seen);
        cmp({tag, ".dut_reset"}, int'(dres), int'(m.phase != P_RUN));
        cmp({tag, ".running"}, int'(run), int'(m.phase == P_RUN));
        cmp({tag, ".done"}, int'(dn), int'(m.phase == P_DONE));
        cmp({tag, ".pass"}, int'(ps), int'(m.phase == P_DONE && m.seen == 0 && m.tmo == 0));
        cmp({tag, ".timeout"}, int'(tmo), m.tmo);
        cmp({tag, ".cycle_count"}, cyc, m.cycles);
        cmp({tag, ".error_count"}, err, m.errs);
        cmp({tag, ".first_fail_id"}, ffid, m.ffid);
        cmp({tag, ".fail_seen"}, int'(seen), m.seen);
    endtask

    // Advance one edge, step both models with the sampled inputs, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, rst, st, hlt, cv, cf, 2, 200, 255);
        ms = mstep(ms, rst, st, hlt, cv, cf, 3, 20, 7);
        #1;
        check_dut("a", ma, a_dres, a_run, a_done, a_pass, a_tmo, int'(a_cyc), int'(a_err),
                  int'(a_ffid), a_seen);
        check_dut("s", ms, s_dres, s_run, s_done, s_pass, s_tmo, int'(s_cyc), int'(s_err),
                  int'(s_ffid), s_seen);
    endtask

    task automatic pulse_start();
        st = 1'b1;
        tick();
        st = 1'b0;
    endtask

    task automatic pulse_halt();
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; st = 1'b0; hlt = 1'b0; cv = '0; cf = '0;
        ma = '0; ms = '0;
        repeat (2) tick();
        cmp("reset.dut_reset", int'(a_dres), 1);
        cmp("reset.running", int'(a_run), 0);
        cmp("reset.error_count", int'(a_err), 0);
        rst = 1'b0;
        tick();

        // Basic run: two hold cycles, halt sampled at RUN cycle 10.
        pulse_start();
        cmp("basic.hold0", int'(a_dres), 1);
        tick();
        cmp("basic.hold1", int'(a_dres), 1);
        tick();
        cmp("basic.released", int'(a_dres), 0);
        cmp("basic.running", int'(a_run), 1);
        repeat (10) tick();
        pulse_halt();
        cmp("basic.done", int'(a_done), 1);
        cmp("basic.pass", int'(a_pass), 1);
        cmp("basic.timeout", int'(a_tmo), 0);
        cmp("basic.cycles", int'(a_cyc), 11);

        // Budget expiry on the 20-cycle instance.
        pulse_start();
        repeat (30) tick();
        cmp("budget.done", int'(s_done), 1);
        cmp("budget.timeout", int'(s_tmo), 1);
        cmp("budget.pass", int'(s_pass), 0);
        cmp("budget.cycles", int'(s_cyc), 20);
        cmp("budget.a_running", int'(a_run), 1);
        pulse_halt();
        cmp("budget.a_timeout", int'(a_tmo), 0);

        // Multi-channel failures.
        pulse_start();
        repeat (3) tick();
        cv = 4'b1111; cf = 4'b1010;
        tick();
        cf = 4'b0001;
        tick();
        cv = '0; cf = '0;
        pulse_halt();
        cmp("multi.errors", int'(a_err), 3);
        cmp("multi.ffid", int'(a_ffid), 1);
        cmp("multi.pass", int'(a_pass), 0);
        cmp("multi.s_errors", int'(s_err), 3);

        // Saturation, and fail flags without valid are ignored.
        pulse_start();
        repeat (3) tick();
        cv = 4'b0001; cf = 4'b0001;
        repeat (10) tick();
        cv = 4'b0000; cf = 4'b1111;
        repeat (3) tick();
        cf = '0;
        pulse_halt();
        cmp("sat.s_errors", int'(s_err), 7);
        cmp("sat.a_errors", int'(a_err), 10);
        cmp("sat.ffid", int'(a_ffid), 0);

        // Halt coincident with budget expiry, plus a channel-2 failure.
        pulse_start();
        repeat (3) tick();
        for (int n = 0; n < 40 && s_cyc != 8'd19; n++) tick();
        cmp("simul.reach", int'(s_cyc), 19);
        hlt = 1'b1; cv = 4'b0100; cf = 4'b0100;
        tick();
        hlt = 1'b0; cv = '0; cf = '0;
        cmp("simul.done", int'(s_done), 1);
        cmp("simul.timeout", int'(s_tmo), 0);
        cmp("simul.errors", int'(s_err), 1);
        cmp("simul.ffid", int'(s_ffid), 2);

        // Reset mid-run, start ignored in RUN, restart from DONE.
        pulse_start();
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("midrst.dut_reset", int'(a_dres), 1);
        cmp("midrst.running", int'(a_run), 0);
        cmp("midrst.cycles", int'(a_cyc), 0);
        cmp("midrst.s_dut_reset", int'(s_dres), 1);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        cmp("ign.running", int'(a_run), 1);
        cmp("ign.cycles", int'(a_cyc), 4);
        pulse_halt();
        cmp("restart.pre_done", int'(a_done), 1);
        pulse_start();
        cmp("restart.done", int'(a_done), 0);
        cmp("restart.dut_reset", int'(a_dres), 1);
        cmp("restart.cycles", int'(a_cyc), 0);

        // Randomised traffic checked every cycle by the model.
        for (int k = 0; k < 500; k++) begin
            rst = ($urandom % 64) == 0;
            st  = ($urandom % 8) == 0;
            hlt = ($urandom % 24) == 0;
            cv  = 4'($urandom);
            cf  = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
